// File: rtl/mem_stage.sv
// mem_stage: MEM stage of a 5-stage MIPS pipeline.
//
// Consumes the EX/MEM pipeline register and produces the MEM/WB pipeline register.
// Non-memory instructions pass through with one cycle of latency. Aligned loads and
// stores are issued to data memory over a registered req/ack handshake while the
// upstream stages are stalled. Misaligned accesses and accesses that see no ack
// within TIMEOUT cycles set a sticky bus error and retire as bubbles.
//
// Ports:
//   clk, rst                      clock (rising edge), async active-low reset
//   ALUout, XM_RD, XM_RegWrite    EX/MEM result, destination and write enable
//   XM_MemRead, XM_MemWrite       load / store (both set => store)
//   XM_WD                         store data
//   dmem_rdata, dmem_ack          data memory response
//   MW_RD, MW_Data, MW_RegWrite   MEM/WB pipeline register
//   stall                         freeze PC and IF/ID, ID/EX, EX/MEM
//   dmem_req, dmem_we,
//   dmem_addr, dmem_wdata         registered data memory request
//   bus_err                       sticky error flag, cleared only by reset
module mem_stage #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CW      = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ALUout,
    input  logic [4:0]  XM_RD,
    input  logic        XM_RegWrite,
    input  logic        XM_MemRead,
    input  logic        XM_MemWrite,
    input  logic [31:0] XM_WD,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [4:0]  MW_RD,
    output logic [31:0] MW_Data,
    output logic        MW_RegWrite,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e          r_state;
    state_e          w_state_next;
    logic [CW-1:0]   r_cnt;
    logic [4:0]      r_rd;

    logic            w_memop;
    logic            w_aligned;
    logic            w_timeout;

    assign w_memop   = XM_MemRead | XM_MemWrite;
    assign w_aligned = (ALUout[1:0] == 2'b00);
    assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (w_memop) begin
                    w_state_next = w_aligned ? StReq : StDone;
                end
            end
            StReq: begin
                if (dmem_ack || w_timeout) begin
                    w_state_next = StDone;
                end
            end
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Stall output. Gated by reset so it drops asynchronously even while the
    // EX/MEM register still presents a memory op.
    always_comb begin
        stall = 1'b0;
        if (rst) begin
            case (r_state)
                StIdle:  stall = w_memop & w_aligned;
                StReq:   stall = 1'b1;
                default: stall = 1'b0;
            endcase
        end
    end

    // MEM/WB register, request registers, timeout counter and error flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            MW_RD       <= '0;
            MW_Data     <= '0;
            MW_RegWrite <= 1'b0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= '0;
            dmem_wdata  <= '0;
            bus_err     <= 1'b0;
            r_cnt       <= '0;
            r_rd        <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (!w_memop) begin
                        MW_RD       <= XM_RD;
                        MW_Data     <= ALUout;
                        MW_RegWrite <= XM_RegWrite;
                    end else if (!w_aligned) begin
                        // Misaligned: no request; retire as a bubble, keep MW_Data.
                        bus_err     <= 1'b1;
                        MW_RegWrite <= 1'b0;
                        MW_RD       <= '0;
                    end else begin
                        dmem_addr   <= ALUout;
                        dmem_wdata  <= XM_WD;
                        dmem_we     <= XM_MemWrite;
                        r_rd        <= XM_RD;
                        dmem_req    <= 1'b1;
                        MW_RegWrite <= 1'b0;
                        r_cnt       <= '0;
                    end
                end
                StReq: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        if (!dmem_we) begin
                            MW_Data     <= dmem_rdata;
                            MW_RD       <= r_rd;
                            MW_RegWrite <= 1'b1;
                        end else begin
                            MW_RegWrite <= 1'b0;
                            MW_RD       <= '0;
                        end
                    end else if (w_timeout) begin
                        dmem_req    <= 1'b0;
                        bus_err     <= 1'b1;
                        MW_RegWrite <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                StDone: begin
                    MW_RegWrite <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: table of pass-through vectors plus hand-written
// sequences for loads, stores, timeout, misalignment and reset during a request.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic [31:0] ALUout;
    logic [4:0]  XM_RD;
    logic        XM_RegWrite;
    logic        XM_MemRead;
    logic        XM_MemWrite;
    logic [31:0] XM_WD;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic [4:0]  MW_RD;
    logic [31:0] MW_Data;
    logic        MW_RegWrite;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        bus_err;

    int n_vec;
    int n_err;

    mem_stage #(
        .TIMEOUT(16),
        .CW     (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ALUout     (ALUout),
        .XM_RD      (XM_RD),
        .XM_RegWrite(XM_RegWrite),
        .XM_MemRead (XM_MemRead),
        .XM_MemWrite(XM_MemWrite),
        .XM_WD      (XM_WD),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack),
        .MW_RD      (MW_RD),
        .MW_Data    (MW_Data),
        .MW_RegWrite(MW_RegWrite),
        .stall      (stall),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .bus_err    (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        rw;
        logic        ack;
        logic [31:0] exp_data;
        logic [4:0]  exp_rd;
        logic        exp_rw;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_nop();
        ALUout      = 32'h0;
        XM_RD       = 5'd0;
        XM_RegWrite = 1'b0;
        XM_MemRead  = 1'b0;
        XM_MemWrite = 1'b0;
        XM_WD       = 32'h0;
        dmem_ack    = 1'b0;
        dmem_rdata  = 32'h0;
    endtask

    task automatic drive_load(input logic [31:0] addr, input logic [4:0] rd);
        ALUout      = addr;
        XM_RD       = rd;
        XM_RegWrite = 1'b1;
        XM_MemRead  = 1'b1;
        XM_MemWrite = 1'b0;
        XM_WD       = 32'h0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        vecs[0] = '{32'h0000_0014, 5'd5,  1'b1, 1'b0, 32'h0000_0014, 5'd5,  1'b1};
        vecs[1] = '{32'hFFFF_FFFF, 5'd31, 1'b0, 1'b0, 32'hFFFF_FFFF, 5'd31, 1'b0};
        vecs[2] = '{32'h8000_0001, 5'd0,  1'b1, 1'b1, 32'h8000_0001, 5'd0,  1'b1};
        vecs[3] = '{32'h0000_0003, 5'd17, 1'b1, 1'b1, 32'h0000_0003, 5'd17, 1'b1};
        vecs[4] = '{32'h1234_5678, 5'd12, 1'b0, 1'b0, 32'h1234_5678, 5'd12, 1'b0};

        // Reset state
        rst = 1'b0;
        drive_nop();
        #2;
        check("rst_MW_Data", MW_Data, 32'h0);
        check("rst_MW_RD", {27'h0, MW_RD}, 32'h0);
        check("rst_MW_RegWrite", {31'h0, MW_RegWrite}, 32'h0);
        check("rst_stall", {31'h0, stall}, 32'h0);
        check("rst_dmem_req", {31'h0, dmem_req}, 32'h0);
        check("rst_dmem_addr", dmem_addr, 32'h0);
        check("rst_bus_err", {31'h0, bus_err}, 32'h0);
        #10;
        rst = 1'b1;
        tick();

        // Pass-through table
        for (int i = 0; i < 5; i++) begin
            ALUout      = vecs[i].alu;
            XM_RD       = vecs[i].rd;
            XM_RegWrite = vecs[i].rw;
            XM_MemRead  = 1'b0;
            XM_MemWrite = 1'b0;
            dmem_ack    = vecs[i].ack;
            dmem_rdata  = 32'hA5A5_A5A5;
            #1;
            check("pt_stall", {31'h0, stall}, 32'h0);
            tick();
            check("pt_MW_Data", MW_Data, vecs[i].exp_data);
            check("pt_MW_RD", {27'h0, MW_RD}, {27'h0, vecs[i].exp_rd});
            check("pt_MW_RegWrite", {31'h0, MW_RegWrite}, {31'h0, vecs[i].exp_rw});
            check("pt_dmem_req", {31'h0, dmem_req}, 32'h0);
        end
        drive_nop();
        tick();

        // Load, zero wait states
        drive_load(32'h0000_0100, 5'd8);
        #1;
        check("ld0_stall_idle", {31'h0, stall}, 32'h1);
        tick();
        check("ld0_req", {31'h0, dmem_req}, 32'h1);
        check("ld0_addr", dmem_addr, 32'h0000_0100);
        check("ld0_we", {31'h0, dmem_we}, 32'h0);
        check("ld0_stall_req", {31'h0, stall}, 32'h1);
        check("ld0_bubble", {31'h0, MW_RegWrite}, 32'h0);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        tick();
        check("ld0_MW_Data", MW_Data, 32'hDEAD_BEEF);
        check("ld0_MW_RD", {27'h0, MW_RD}, 32'd8);
        check("ld0_MW_RegWrite", {31'h0, MW_RegWrite}, 32'h1);
        check("ld0_req_done", {31'h0, dmem_req}, 32'h0);
        check("ld0_stall_done", {31'h0, stall}, 32'h0);
        drive_nop();
        tick();
        check("ld0_rw_after", {31'h0, MW_RegWrite}, 32'h0);
        check("ld0_data_hold", MW_Data, 32'hDEAD_BEEF);

        // Store, ack after three wait cycles
        ALUout      = 32'h0000_0200;
        XM_RD       = 5'd0;
        XM_RegWrite = 1'b0;
        XM_MemWrite = 1'b1;
        XM_WD       = 32'h1234_5678;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("st_req", {31'h0, dmem_req}, 32'h1);
            check("st_we", {31'h0, dmem_we}, 32'h1);
            check("st_addr", dmem_addr, 32'h0000_0200);
            check("st_wdata", dmem_wdata, 32'h1234_5678);
            check("st_stall", {31'h0, stall}, 32'h1);
            check("st_rw", {31'h0, MW_RegWrite}, 32'h0);
            tick();
        end
        dmem_ack = 1'b1;
        tick();
        check("st_req_done", {31'h0, dmem_req}, 32'h0);
        check("st_stall_done", {31'h0, stall}, 32'h0);
        check("st_rw_done", {31'h0, MW_RegWrite}, 32'h0);
        check("st_rd_done", {27'h0, MW_RD}, 32'h0);
        drive_nop();
        tick();

        // Timeout: load never acknowledged
        check("to_err_before", {31'h0, bus_err}, 32'h0);
        drive_load(32'h0000_0300, 5'd9);
        tick();
        for (int i = 0; i < 16; i++) begin
            check("to_req_held", {31'h0, dmem_req}, 32'h1);
            tick();
        end
        check("to_req_drop", {31'h0, dmem_req}, 32'h0);
        check("to_bus_err", {31'h0, bus_err}, 32'h1);
        check("to_rw", {31'h0, MW_RegWrite}, 32'h0);
        check("to_stall_done", {31'h0, stall}, 32'h0);
        drive_nop();
        tick();
        ALUout      = 32'h0000_0044;
        XM_RD       = 5'd3;
        XM_RegWrite = 1'b1;
        tick();
        check("to_pt_data", MW_Data, 32'h0000_0044);
        check("to_pt_rd", {27'h0, MW_RD}, 32'd3);
        check("to_pt_rw", {31'h0, MW_RegWrite}, 32'h1);
        check("to_err_sticky", {31'h0, bus_err}, 32'h1);

        // Reset during a request
        drive_load(32'h0000_0400, 5'd10);
        tick();
        check("rr_req_before", {31'h0, dmem_req}, 32'h1);
        #1;
        rst = 1'b0;
        #1;
        check("rr_req", {31'h0, dmem_req}, 32'h0);
        check("rr_stall", {31'h0, stall}, 32'h0);
        check("rr_bus_err", {31'h0, bus_err}, 32'h0);
        check("rr_MW_Data", MW_Data, 32'h0);
        check("rr_MW_RD", {27'h0, MW_RD}, 32'h0);
        check("rr_addr", dmem_addr, 32'h0);
        check("rr_we", {31'h0, dmem_we}, 32'h0);
        #1;
        rst = 1'b1;
        #1;
        check("rr_stall_after", {31'h0, stall}, 32'h1);
        tick();
        check("rr_req_new", {31'h0, dmem_req}, 32'h1);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hCAFE_F00D;
        tick();
        check("rr_ld_data", MW_Data, 32'hCAFE_F00D);
        check("rr_ld_rd", {27'h0, MW_RD}, 32'd10);
        check("rr_ld_rw", {31'h0, MW_RegWrite}, 32'h1);
        drive_nop();
        tick();

        // Misaligned load
        drive_load(32'h0000_0102, 5'd7);
        #1;
        check("ma_stall_idle", {31'h0, stall}, 32'h0);
        tick();
        check("ma_req", {31'h0, dmem_req}, 32'h0);
        check("ma_bus_err", {31'h0, bus_err}, 32'h1);
        check("ma_rw", {31'h0, MW_RegWrite}, 32'h0);
        check("ma_rd", {27'h0, MW_RD}, 32'h0);
        check("ma_data_hold", MW_Data, 32'hCAFE_F00D);
        check("ma_stall_done", {31'h0, stall}, 32'h0);
        drive_nop();
        tick();
        check("ma_req_idle", {31'h0, dmem_req}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
